// File: rtl/rv32i_encoder.sv
// rv32i_encoder: packs decoded RV32I instruction fields into a 32-bit word.
// The encoder range-checks the fields, so an illegal entry becomes {inst=0, err=1}.
// Results queue in a 2-entry FIFO that has its own valid/ready handshake, and two
// counters track how many legal and illegal instructions were accepted.
module rv32i_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_format,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt_ok,
  output logic [CNT_W-1:0] o_cnt_err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]      enc_inst;
  logic             fmt_ok;
  logic             imm_ok;
  logic             new_err;
  logic [31:0]      new_inst;

  // The head slot always holds the oldest entry. The tail slot is used only
  // while count == 2.
  logic [1:0]       count;
  logic [31:0]      head_inst;
  logic             head_err;
  logic [31:0]      tail_inst;
  logic             tail_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  logic             push;
  logic             pop;

  // Pack the fields for the selected format and check the immediate range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    enc_inst = 32'h0;
    fmt_ok   = 1'b1;
    imm_ok   = 1'b1;
    case (i_format)
      FMT_R: begin
        enc_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        imm_ok   = (i_imm[31:11] == {21{i_imm[11]}});
      end
      FMT_S: begin
        enc_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        imm_ok   = (i_imm[31:11] == {21{i_imm[11]}});
      end
      FMT_B: begin
        enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
        imm_ok   = (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0];
      end
      FMT_U: begin
        enc_inst = {i_imm[31:12], i_rd, i_opcode};
        imm_ok   = (i_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        enc_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        imm_ok   = (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0];
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase
    new_err  = (i_opcode[1:0] != 2'b11) || !fmt_ok || !imm_ok;
    new_inst = new_err ? 32'h0 : enc_inst;
  end

  // The handshake depends only on registered state and reset. A full FIFO
  // therefore never accepts in the same cycle that it pops.
  assign o_ready = !i_rst && (count < 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // FIFO slots, occupancy and the accepted/error counters.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then sample pre-edge values, and the slot-shift order does not matter.
    if (i_rst) begin
      count     <= 2'd0;
      head_inst <= 32'h0;
      head_err  <= 1'b0;
      tail_inst <= 32'h0;
      tail_err  <= 1'b0;
      cnt_ok    <= '0;
      cnt_err   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_inst <= new_inst;
            head_err  <= new_err;
          end else begin
            tail_inst <= new_inst;
            tail_err  <= new_err;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_inst <= tail_inst;
          head_err  <= tail_err;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // A push needs count < 2 and a pop needs count > 0, so count is 1
          // here. The new entry replaces the departing head.
          head_inst <= new_inst;
          head_err  <= new_err;
        end
        default: ;
      endcase
      if (push) begin
        if (new_err) cnt_err <= cnt_err + CNT_W'(1);
        else         cnt_ok  <= cnt_ok + CNT_W'(1);
      end
    end
  end

  assign o_inst    = o_valid ? head_inst : 32'h0;
  assign o_err     = o_valid && head_err;
  assign o_cnt_ok  = cnt_ok;
  assign o_cnt_err = cnt_err;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed bench for rv32i_encoder. The stimulus covers a table of legal and
// illegal encodings streamed at full rate, back-pressure, a mid-stream reset,
// and counter wrap on a narrow-counter instance.
module tb_rv32i_encoder;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_format;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic [15:0] o_cnt_ok;
  logic [15:0] o_cnt_err;

  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_inst;
  logic        w_err;
  logic [1:0]  w_cnt_ok;
  logic [1:0]  w_cnt_err;

  rv32i_encoder #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_format(i_format), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_err(o_err),
    .o_cnt_ok(o_cnt_ok), .o_cnt_err(o_cnt_err)
  );

  rv32i_encoder #(.CNT_W(2)) dut_wrap (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(w_ready),
    .i_format(i_format), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(w_valid), .i_ready(i_ready), .o_inst(w_inst), .o_err(w_err),
    .o_cnt_ok(w_cnt_ok), .o_cnt_err(w_cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    i_format = v.fmt;
    i_opcode = v.op;
    i_rd     = v.rd;
    i_rs1    = v.rs1;
    i_rs2    = v.rs2;
    i_funct3 = v.f3;
    i_funct7 = v.f7;
    i_imm    = v.imm;
  endtask

  initial begin
    int exp_ok;
    int exp_err;

    //          fmt   op     rd  rs1 rs2 f3  f7     imm           inst          err
    vecs[0]  = '{3'd1, 7'h03, 0,  0,  0,  0,  7'h00, 32'h00000000, 32'h00000003, 1'b0}; // LB x0,0(x0)
    vecs[1]  = '{3'd1, 7'h13, 1,  0,  0,  0,  7'h00, 32'h00000005, 32'h00500093, 1'b0}; // ADDI x1,x0,5
    vecs[2]  = '{3'd0, 7'h33, 3,  1,  2,  0,  7'h00, 32'h00000000, 32'h002081B3, 1'b0}; // ADD x3,x1,x2
    vecs[3]  = '{3'd2, 7'h23, 0,  1,  2,  2,  7'h00, 32'h00000008, 32'h0020A423, 1'b0}; // SW x2,8(x1)
    vecs[4]  = '{3'd3, 7'h63, 0,  1,  2,  0,  7'h00, 32'h00000010, 32'h00208863, 1'b0}; // BEQ x1,x2,+16
    vecs[5]  = '{3'd4, 7'h37, 5,  0,  0,  0,  7'h00, 32'h12345000, 32'h123452B7, 1'b0}; // LUI x5
    vecs[6]  = '{3'd5, 7'h6F, 1,  0,  0,  0,  7'h00, 32'h00000800, 32'h001000EF, 1'b0}; // JAL x1,+2048
    vecs[7]  = '{3'd2, 7'h23, 0,  1,  2,  2,  7'h00, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0}; // SW x2,-4(x1)
    vecs[8]  = '{3'd3, 7'h63, 0,  1,  2,  1,  7'h00, 32'hFFFFFFF8, 32'hFE209CE3, 1'b0}; // BNE x1,x2,-8
    vecs[9]  = '{3'd1, 7'h13, 1,  0,  0,  0,  7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0}; // ADDI x1,x0,-1
    vecs[10] = '{3'd0, 7'h33, 3,  1,  2,  0,  7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0}; // SUB, junk imm ignored
    vecs[11] = '{3'd4, 7'h37, 5, 31, 31,  7,  7'h7F, 32'h12345000, 32'h123452B7, 1'b0}; // LUI, junk fields ignored
    vecs[12] = '{3'd1, 7'h13, 1,  0,  0,  0,  7'h00, 32'h00000800, 32'h00000000, 1'b1}; // I imm 2048
    vecs[13] = '{3'd3, 7'h63, 0,  1,  2,  0,  7'h00, 32'h00000003, 32'h00000000, 1'b1}; // B imm 3
    vecs[14] = '{3'd4, 7'h37, 5,  0,  0,  0,  7'h00, 32'h00000001, 32'h00000000, 1'b1}; // U imm 1
    vecs[15] = '{3'd1, 7'h12, 1,  0,  0,  0,  7'h00, 32'h00000000, 32'h00000000, 1'b1}; // opcode 0010010
    vecs[16] = '{3'd7, 7'h13, 1,  0,  0,  0,  7'h00, 32'h00000000, 32'h00000000, 1'b1}; // format 7
    vecs[17] = '{3'd5, 7'h6F, 1,  0,  0,  0,  7'h00, 32'h00100000, 32'h00000000, 1'b1}; // J imm 2^20
    vecs[18] = '{3'd6, 7'h13, 1,  0,  0,  0,  7'h00, 32'h00000000, 32'h00000000, 1'b1}; // format 6
    vecs[19] = '{3'd1, 7'h13, 1,  0,  0,  0,  7'h00, 32'h00000005, 32'h00500093, 1'b0}; // legal after illegal

    // Reset. Inputs offered while reset is high must be dropped.
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b0;
    apply(vecs[1]);
    step();
    step();
    check("rst o_ready", 32'(o_ready), 32'd0);
    check("rst o_valid", 32'(o_valid), 32'd0);
    check("rst cnt_ok", 32'(o_cnt_ok), 32'd0);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    step();
    check("post-rst o_valid", 32'(o_valid), 32'd0);
    check("post-rst o_inst", o_inst, 32'd0);
    check("post-rst o_err", 32'(o_err), 32'd0);
    check("post-rst o_ready", 32'(o_ready), 32'd1);
    check("post-rst cnt_ok", 32'(o_cnt_ok), 32'd0);
    check("post-rst cnt_err", 32'(o_cnt_err), 32'd0);

    // Full-rate stream. Each entry must be at the head one cycle after its accept.
    exp_ok  = 0;
    exp_err = 0;
    i_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      i_valid = 1'b1;
      step();
      if (vecs[i].err) exp_err++;
      else             exp_ok++;
      check($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'd1);
      check($sformatf("vec%0d o_inst", i), o_inst, vecs[i].inst);
      check($sformatf("vec%0d o_err", i), 32'(o_err), 32'(vecs[i].err));
      check($sformatf("vec%0d o_ready", i), 32'(o_ready), 32'd1);
    end
    i_valid = 1'b0;
    step();
    check("stream drained", 32'(o_valid), 32'd0);
    check("stream cnt_ok", 32'(o_cnt_ok), 32'(exp_ok));
    check("stream cnt_err", 32'(o_cnt_err), 32'(exp_err));

    // Back-pressure. Offer A, B and C while i_ready=0. Only A and B fit.
    i_ready = 1'b0;
    i_valid = 1'b1;
    apply(vecs[1]);
    step();
    check("bp1 o_ready", 32'(o_ready), 32'd1);
    check("bp1 head", o_inst, 32'h00500093);
    apply(vecs[2]);
    step();
    check("bp2 o_ready", 32'(o_ready), 32'd0);
    check("bp2 head", o_inst, 32'h00500093);
    apply(vecs[3]);
    step();
    check("bp3 o_ready held low", 32'(o_ready), 32'd0);
    check("bp3 head stable", o_inst, 32'h00500093);
    check("bp3 o_err stable", 32'(o_err), 32'd0);
    i_ready = 1'b1;
    step();
    check("bp pop1 head", o_inst, 32'h002081B3);
    check("bp pop1 o_ready", 32'(o_ready), 32'd1);
    step();
    check("bp pop+push head", o_inst, 32'h0020A423);
    check("bp pop+push valid", 32'(o_valid), 32'd1);
    i_valid = 1'b0;
    step();
    check("bp drained", 32'(o_valid), 32'd0);
    exp_ok += 3;
    check("bp cnt_ok", 32'(o_cnt_ok), 32'(exp_ok));

    // Mid-stream reset with the FIFO full and the counters non-zero.
    i_ready = 1'b0;
    i_valid = 1'b1;
    apply(vecs[4]);
    step();
    apply(vecs[5]);
    step();
    check("mid full", 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    apply(vecs[6]);
    step();
    check("mid rst o_valid", 32'(o_valid), 32'd0);
    check("mid rst o_inst", o_inst, 32'd0);
    check("mid rst cnt_ok", 32'(o_cnt_ok), 32'd0);
    check("mid rst cnt_err", 32'(o_cnt_err), 32'd0);
    check("mid rst o_ready", 32'(o_ready), 32'd0);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid no ghost %0d", k), 32'(o_valid), 32'd0);
    end
    check("mid cnt_ok stays 0", 32'(o_cnt_ok), 32'd0);

    // Counter wrap on the 2-bit instance: 5 legal pushes give 5 mod 4 = 1.
    apply(vecs[1]);
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    i_valid = 1'b0;
    step();
    check("wrap cnt_ok", 32'(w_cnt_ok), 32'd1);
    check("wrap cnt_err", 32'(w_cnt_err), 32'd0);
    check("wide cnt_ok", 32'(o_cnt_ok), 32'd5);
    check("wrap drained", 32'(w_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
